// File: rtl/hub75_rx_monitor.sv
// hub75_rx_monitor: HUB75 panel-side receiver rebuilding latched rows into a pixel stream
module hub75_rx_monitor #(
  parameter int N_BANKS = 2,
  parameter int N_ROWS  = 32,
  parameter int N_COLS  = 96,
  parameter int N_CHANS = 3,
  parameter int AW = $clog2(N_ROWS),
  parameter int CW = $clog2(N_COLS),
  parameter int DW = N_BANKS * N_CHANS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] hub75_addr,
  input  logic [DW-1:0] hub75_data,
  input  logic          hub75_clk,
  input  logic          hub75_le,
  input  logic          hub75_blank,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [AW-1:0] px_row,
  output logic [CW-1:0] px_col,
  output logic [DW-1:0] px_data,
  output logic          px_last,
  output logic [15:0]   px_on_len,
  output logic          err_len,
  output logic          err_ovf,
  input  logic          err_clr
);
  localparam int WCW = $clog2(N_COLS + 1);
  localparam logic [WCW-1:0] W_FULL = WCW'(N_COLS);
  localparam logic [CW-1:0] C_LAST = CW'(N_COLS - 1);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t state, state_n;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic s1_clk, s2_clk, s1_le, s2_le, s1_blank;
  logic [DW-1:0] mem [2][N_COLS];
  logic wsel, too_many, too_many_n, clk_edge, le_edge, wr_en, line_ok, busy, commit, hs;
  logic [WCW-1:0] wcol;
  logic [15:0] on_cnt, on_cnt_n;
  logic [CW-1:0] rcol;
  always_comb begin
    clk_edge = s1_clk & ~s2_clk;
    le_edge = s1_le & ~s2_le;
    wr_en = clk_edge && wcol != W_FULL;
    too_many_n = too_many | (clk_edge && wcol == W_FULL);
    on_cnt_n = (!s1_blank && on_cnt != 16'hFFFF) ? on_cnt + 16'd1 : on_cnt;
    line_ok = (wr_en ? wcol + WCW'(1) : wcol) == W_FULL && !too_many_n;
    busy = state != IDLE;
    commit = le_edge && line_ok && !busy;
    px_valid = state == VALID;
    px_last = rcol == C_LAST;
    px_col = rcol;
    hs = px_valid && px_ready;
    state_n = state == IDLE ? (commit ? FETCH : IDLE) :
              state == FETCH ? VALID :
              hs ? (px_last ? IDLE : FETCH) : VALID;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_addr, s1_data, s1_clk, s2_clk, s1_le, s2_le, s1_blank} <= '0;
    end else begin
      {s1_addr, s1_data, s1_clk, s1_le, s1_blank} <= {hub75_addr, hub75_data, hub75_clk, hub75_le, hub75_blank};
      {s2_clk, s2_le} <= {s1_clk, s1_le};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wcol <= '0;
      too_many <= 1'b0;
      on_cnt <= '0;
      wsel <= 1'b0;
      err_len <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      wcol <= le_edge ? '0 : wr_en ? wcol + WCW'(1) : wcol;
      too_many <= !le_edge && too_many_n;
      on_cnt <= le_edge ? '0 : on_cnt_n;
      wsel <= commit ? ~wsel : wsel;
      err_len <= (le_edge && !line_ok) || (err_len && !err_clr);
      err_ovf <= (le_edge && line_ok && busy) || (err_ovf && !err_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wsel][wcol[CW-1:0]] <= s1_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcol <= '0;
      px_data <= '0;
      px_row <= '0;
      px_on_len <= '0;
    end else begin
      state <= state_n;
      if (commit) begin
        px_row <= s1_addr;
        px_on_len <= on_cnt_n;
      end
      if (state == FETCH) px_data <= mem[~wsel][rcol];
      if (hs) rcol <= px_last ? '0 : rcol + CW'(1);
    end
  end
endmodule

// File: tb/tb_hub75_rx_monitor.sv
// tb_hub75_rx_monitor: directed scoreboard bench for hub75_rx_monitor
module tb_hub75_rx_monitor;
  localparam int AW = 5, CW = 7, DW = 6, NC = 96;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] hub75_addr = '0;
  logic [DW-1:0] hub75_data = '0;
  logic hub75_clk = 1'b0, hub75_le = 1'b0, hub75_blank = 1'b1;
  logic px_valid, px_ready = 1'b1, px_last, err_len, err_ovf, err_clr = 1'b0;
  logic [AW-1:0] px_row;
  logic [CW-1:0] px_col;
  logic [DW-1:0] px_data;
  logic [15:0] px_on_len;
  typedef struct {int row; int col; int data; int last; int on_len;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hub75_rx_monitor dut (
    .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
    .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
    .px_valid(px_valid), .px_ready(px_ready), .px_row(px_row), .px_col(px_col),
    .px_data(px_data), .px_last(px_last), .px_on_len(px_on_len),
    .err_len(err_len), .err_ovf(err_ovf), .err_clr(err_clr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulses(input int n, input int seed, input int on);
    for (int c = 0; c < n; c++) begin
      hub75_data = DW'(c + seed);
      hub75_clk = 1'b1;
      hub75_blank = (2 * c >= on);
      tick();
      hub75_clk = 1'b0;
      hub75_blank = (2 * c + 1 >= on);
      tick();
    end
    hub75_blank = 1'b1;
  endtask
  task automatic send_line(input int row, input int n, input int seed, input int on,
                           input bit le_same, input bit expect_out, input int exp_on);
    hub75_addr = AW'(row);
    pulses(le_same ? n - 1 : n, seed, on);
    if (le_same) begin
      hub75_data = DW'(n - 1 + seed);
      hub75_clk = 1'b1;
    end
    hub75_le = 1'b1;
    tick();
    if (expect_out)
      for (int c = 0; c < NC; c++) q.push_back('{row, c, (c + seed) & 63, int'(c == NC - 1), exp_on});
    hub75_clk = 1'b0;
    hub75_le = 1'b0;
    tick();
  endtask
  task automatic drain(input string tag, output int n);
    n = 0;
    while (q.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, q.size(), 0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, px_valid, 0);
    chk({tag, "_col"}, px_col, 0);
    chk({tag, "_last"}, px_last, 0);
    chk({tag, "_row"}, px_row, 0);
    chk({tag, "_data"}, px_data, 0);
    chk({tag, "_on_len"}, px_on_len, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (px_valid && px_ready) begin
      if (q.size() == 0) chk("px_unexpected_valid", px_valid, 0);
      else begin
        e = q.pop_front();
        chk("px_row", px_row, e.row);
        chk("px_col", px_col, e.col);
        chk("px_data", px_data, e.data);
        chk("px_last", px_last, e.last);
        if (e.on_len >= 0) chk("px_on_len", px_on_len, e.on_len);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
  initial begin
    int n, lat;
    repeat (3) tick();
    chk_reset_outputs("rst0");
    rst = 1'b0;
    tick();
    send_line(3, 95, 0, 0, 0, 0, 0);
    repeat (6) tick();
    chk("short_err_len", err_len, 1);
    chk("short_no_valid", px_valid, 0);
    chk("short_err_ovf", err_ovf, 0);
    send_line(4, 97, 0, 0, 0, 0, 0);
    repeat (6) tick();
    chk("long_err_len", err_len, 1);
    chk("long_no_valid", px_valid, 0);
    pulses(3, 0, 0);
    hub75_le = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    hub75_le = 1'b0;
    chk("clr_vs_set_err_len", err_len, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_alone_err_len", err_len, 0);
    repeat (2) tick();
    send_line(5, NC, 0, 40, 0, 1, 40);
    lat = 2;
    while (!px_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("first_valid_within_4", px_valid && lat <= 4, 1);
    drain("row5", n);
    chk("row5_two_clk_per_px", n <= 2 * NC + 4, 1);
    repeat (4) tick();
    chk("row5_idle", px_valid, 0);
    chk("row5_err_len", err_len, 0);
    chk("row5_err_ovf", err_ovf, 0);
    send_line(9, NC, 20, 0, 1, 1, 0);
    drain("row9_same_cycle", n);
    chk("row9_err_len", err_len, 0);
    px_ready = 1'b0;
    send_line(1, NC, 30, 10, 0, 1, 10);
    repeat (5) tick();
    chk("stall_valid", px_valid, 1);
    chk("stall_col", px_col, 0);
    chk("stall_row", px_row, 1);
    send_line(2, NC, 50, 0, 0, 0, 0);
    repeat (4) tick();
    chk("ovf_err_ovf", err_ovf, 1);
    chk("ovf_err_len", err_len, 0);
    px_ready = 1'b1;
    drain("row1_after_ovf", n);
    repeat (6) tick();
    chk("row2_dropped", px_valid, 0);
    hub75_addr = AW'(12);
    pulses(50, 0, 0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst1");
    rst = 1'b0;
    tick();
    send_line(7, NC, 3, 0, 0, 1, -1);
    drain("row7_after_rst", n);
    repeat (4) tick();
    chk("row7_idle", px_valid, 0);
    chk("row7_err_len", err_len, 0);
    chk("row7_err_ovf", err_ovf, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
